// File: rtl/ex_mem_tracker.sv
// Execute-stage trace tracker: pairs in-order trace elements with data-memory transactions
// and emits one result per element with grant/rvalid timestamps and latency.
module ex_mem_tracker #(
  parameter int unsigned DATA_ADDR_WIDTH = 32,
  parameter int unsigned ELEM_WIDTH      = 64,
  parameter int unsigned CNT_WIDTH       = 32,
  parameter int unsigned ELEM_DEPTH      = 16,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned TXN_DEPTH       = 8,
  parameter int unsigned TIMEOUT         = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [CNT_WIDTH-1:0]       counter,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ELEM_WIDTH-1:0]      in_elem,
  input  logic                       in_is_mem,
  input  logic                       data_mem_req,
  input  logic [DATA_ADDR_WIDTH-1:0] data_mem_addr,
  input  logic                       data_mem_we,
  input  logic                       data_mem_grant,
  input  logic                       data_mem_rvalid,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ELEM_WIDTH-1:0]      out_elem,
  output logic                       out_is_mem,
  output logic [DATA_ADDR_WIDTH-1:0] out_mem_addr,
  output logic                       out_we,
  output logic [CNT_WIDTH-1:0]       out_start,
  output logic [CNT_WIDTH-1:0]       out_end,
  output logic [CNT_WIDTH-1:0]       out_latency,
  output logic                       out_timeout,
  output logic                       err_overflow,
  output logic                       err_spurious
);

  localparam int unsigned EAW = (ELEM_DEPTH > 1) ? $clog2(ELEM_DEPTH) : 1;
  localparam int unsigned ECW = $clog2(ELEM_DEPTH + 1);
  localparam int unsigned PAW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned PCW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned CAW = (TXN_DEPTH > 1) ? $clog2(TXN_DEPTH) : 1;
  localparam int unsigned CCW = $clog2(TXN_DEPTH + 1);
  localparam int unsigned PW  = DATA_ADDR_WIDTH + 1 + CNT_WIDTH;
  localparam int unsigned CW  = PW + CNT_WIDTH;
  localparam logic [31:0] TimeoutLast = (TIMEOUT == 0) ? 32'd0 : 32'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StWaitTxn, StEmit} state_e;

  // Element FIFO: {elem, is_mem}
  logic [ELEM_WIDTH:0] elem_mem_q [ELEM_DEPTH];
  logic [EAW-1:0]      elem_wr_q, elem_rd_q;
  logic [ECW-1:0]      elem_cnt_q;
  logic                elem_full, elem_empty, elem_push, elem_pop;
  logic [ELEM_WIDTH:0] elem_head;

  assign elem_full  = (elem_cnt_q == ECW'(ELEM_DEPTH));
  assign elem_empty = (elem_cnt_q == '0);
  assign elem_push  = in_valid && !elem_full;
  assign elem_head  = elem_mem_q[elem_rd_q];
  assign in_ready   = !elem_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      elem_wr_q  <= '0;
      elem_rd_q  <= '0;
      elem_cnt_q <= '0;
    end else begin
      if (elem_push) elem_wr_q <= (elem_wr_q == EAW'(ELEM_DEPTH - 1)) ? '0 : elem_wr_q + 1'b1;
      if (elem_pop)  elem_rd_q <= (elem_rd_q == EAW'(ELEM_DEPTH - 1)) ? '0 : elem_rd_q + 1'b1;
      elem_cnt_q <= elem_cnt_q + ECW'(elem_push) - ECW'(elem_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (elem_push) elem_mem_q[elem_wr_q] <= {in_elem, in_is_mem};
  end

  // Pending FIFO: {addr, we, start}
  logic [PW-1:0]  pend_mem_q [MAX_OUTSTANDING];
  logic [PAW-1:0] pend_wr_q, pend_rd_q;
  logic [PCW-1:0] pend_cnt_q;
  logic           pend_full, pend_empty, pend_push, pend_pop, pend_ovf, spurious;
  logic           granted;

  assign granted    = data_mem_req && data_mem_grant;
  assign pend_full  = (pend_cnt_q == PCW'(MAX_OUTSTANDING));
  assign pend_empty = (pend_cnt_q == '0);
  assign pend_push  = granted && !pend_full;
  assign pend_ovf   = granted && pend_full;
  assign pend_pop   = data_mem_rvalid && !pend_empty;
  assign spurious   = data_mem_rvalid && pend_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_wr_q  <= '0;
      pend_rd_q  <= '0;
      pend_cnt_q <= '0;
    end else begin
      if (pend_push) pend_wr_q <= (pend_wr_q == PAW'(MAX_OUTSTANDING - 1)) ? '0 : pend_wr_q + 1'b1;
      if (pend_pop)  pend_rd_q <= (pend_rd_q == PAW'(MAX_OUTSTANDING - 1)) ? '0 : pend_rd_q + 1'b1;
      pend_cnt_q <= pend_cnt_q + PCW'(pend_push) - PCW'(pend_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (pend_push) pend_mem_q[pend_wr_q] <= {data_mem_addr, data_mem_we, counter};
  end

  // Completed FIFO: {addr, we, start, end}
  logic [CW-1:0]  cpl_mem_q [TXN_DEPTH];
  logic [CAW-1:0] cpl_wr_q, cpl_rd_q;
  logic [CCW-1:0] cpl_cnt_q;
  logic           cpl_full, cpl_empty, cpl_push, cpl_pop, cpl_ovf;
  logic [CW-1:0]  cpl_head;

  assign cpl_full  = (cpl_cnt_q == CCW'(TXN_DEPTH));
  assign cpl_empty = (cpl_cnt_q == '0);
  assign cpl_push  = pend_pop && !cpl_full;
  assign cpl_ovf   = pend_pop && cpl_full;
  assign cpl_head  = cpl_mem_q[cpl_rd_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      cpl_wr_q  <= '0;
      cpl_rd_q  <= '0;
      cpl_cnt_q <= '0;
    end else begin
      if (cpl_push) cpl_wr_q <= (cpl_wr_q == CAW'(TXN_DEPTH - 1)) ? '0 : cpl_wr_q + 1'b1;
      if (cpl_pop)  cpl_rd_q <= (cpl_rd_q == CAW'(TXN_DEPTH - 1)) ? '0 : cpl_rd_q + 1'b1;
      cpl_cnt_q <= cpl_cnt_q + CCW'(cpl_push) - CCW'(cpl_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (cpl_push) cpl_mem_q[cpl_wr_q] <= {pend_mem_q[pend_rd_q], counter};
  end

  // Pairing FSM
  state_e      state_q, state_d;
  logic [31:0] timer_q, timer_d;
  logic        cap_en, cap_mem, cap_to;

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    elem_pop = 1'b0;
    cpl_pop  = 1'b0;
    cap_en   = 1'b0;
    cap_mem  = 1'b0;
    cap_to   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!elem_empty) begin
          if (!elem_head[0]) begin
            cap_en   = 1'b1;
            elem_pop = 1'b1;
            state_d  = StEmit;
          end else if (!cpl_empty) begin
            cap_en   = 1'b1;
            cap_mem  = 1'b1;
            elem_pop = 1'b1;
            cpl_pop  = 1'b1;
            state_d  = StEmit;
          end else begin
            timer_d = '0;
            state_d = StWaitTxn;
          end
        end
      end
      StWaitTxn: begin
        if (!cpl_empty) begin
          cap_en   = 1'b1;
          cap_mem  = 1'b1;
          elem_pop = 1'b1;
          cpl_pop  = 1'b1;
          state_d  = StEmit;
        end else if ((TIMEOUT != 0) && (timer_q == TimeoutLast)) begin
          cap_en   = 1'b1;
          cap_to   = 1'b1;
          elem_pop = 1'b1;
          state_d  = StEmit;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      StEmit: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  logic [ELEM_WIDTH-1:0]      out_elem_q;
  logic                       out_is_mem_q, out_we_q, out_timeout_q;
  logic [DATA_ADDR_WIDTH-1:0] out_addr_q;
  logic [CNT_WIDTH-1:0]       out_start_q, out_end_q;
  logic                       err_overflow_q, err_spurious_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      timer_q        <= '0;
      out_elem_q     <= '0;
      out_is_mem_q   <= 1'b0;
      out_addr_q     <= '0;
      out_we_q       <= 1'b0;
      out_start_q    <= '0;
      out_end_q      <= '0;
      out_timeout_q  <= 1'b0;
      err_overflow_q <= 1'b0;
      err_spurious_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      err_overflow_q <= err_overflow_q | pend_ovf | cpl_ovf;
      err_spurious_q <= err_spurious_q | spurious;
      if (cap_en) begin
        out_elem_q    <= elem_head[ELEM_WIDTH:1];
        out_is_mem_q  <= elem_head[0];
        out_addr_q    <= cap_mem ? cpl_head[CW-1 -: DATA_ADDR_WIDTH] : '0;
        out_we_q      <= cap_mem ? cpl_head[2*CNT_WIDTH] : 1'b0;
        out_start_q   <= cap_mem ? cpl_head[2*CNT_WIDTH-1 -: CNT_WIDTH] : '0;
        out_end_q     <= cap_mem ? cpl_head[CNT_WIDTH-1:0] : '0;
        out_timeout_q <= cap_to;
      end
    end
  end

  assign out_valid    = (state_q == StEmit);
  assign out_elem     = out_elem_q;
  assign out_is_mem   = out_is_mem_q;
  assign out_mem_addr = out_addr_q;
  assign out_we       = out_we_q;
  assign out_start    = out_start_q;
  assign out_end      = out_end_q;
  // Modular subtraction handles counter wrap between grant and rvalid
  assign out_latency  = out_end_q - out_start_q;
  assign out_timeout  = out_timeout_q;
  assign err_overflow = err_overflow_q;
  assign err_spurious = err_spurious_q;

endmodule

// File: tb/tb_ex_mem_tracker.sv
// Directed bench for ex_mem_tracker: a cycle-by-cycle vector table plus hand-written sequences
// for timeout, counter wrap, backpressure and mid-operation reset.
module tb_ex_mem_tracker;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] counter;
  logic        in_valid, in_ready, in_is_mem;
  logic [63:0] in_elem;
  logic        data_mem_req, data_mem_we, data_mem_grant, data_mem_rvalid;
  logic [31:0] data_mem_addr;
  logic        out_valid, out_ready, out_is_mem, out_we, out_timeout;
  logic [63:0] out_elem;
  logic [31:0] out_mem_addr, out_start, out_end, out_latency;
  logic        err_overflow, err_spurious;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ex_mem_tracker #(.TIMEOUT(8)) dut (
    .clk             (clk),
    .rst             (rst),
    .counter         (counter),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_elem         (in_elem),
    .in_is_mem       (in_is_mem),
    .data_mem_req    (data_mem_req),
    .data_mem_addr   (data_mem_addr),
    .data_mem_we     (data_mem_we),
    .data_mem_grant  (data_mem_grant),
    .data_mem_rvalid (data_mem_rvalid),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_elem        (out_elem),
    .out_is_mem      (out_is_mem),
    .out_mem_addr    (out_mem_addr),
    .out_we          (out_we),
    .out_start       (out_start),
    .out_end         (out_end),
    .out_latency     (out_latency),
    .out_timeout     (out_timeout),
    .err_overflow    (err_overflow),
    .err_spurious    (err_spurious)
  );

  typedef struct {
    logic        iv;
    logic [63:0] elem;
    logic        im;
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic        gnt;
    logic        rv;
    logic [31:0] cnt;
    logic        chk;
    logic        e_ov;
    logic [63:0] e_elem;
    logic        e_mem;
    logic [31:0] e_addr;
    logic        e_we;
    logic [31:0] e_start;
    logic [31:0] e_end;
    logic [31:0] e_lat;
    logic        e_eo;
    logic        e_es;
  } vec_t;

  vec_t tbl[$];

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic iv, input logic [63:0] el, input logic im, input logic rq,
                     input logic [31:0] ad, input logic w, input logic g, input logic rv,
                     input logic [31:0] c);
    vec_t v;
    v = '{default: '0};
    v.iv = iv; v.elem = el; v.im = im; v.req = rq; v.addr = ad; v.we = w;
    v.gnt = g; v.rv = rv; v.cnt = c;
    tbl.push_back(v);
  endtask

  task automatic exp_idle(input logic eo, input logic es);
    vec_t v;
    v = tbl[tbl.size()-1];
    v.chk = 1'b1; v.e_ov = 1'b0; v.e_eo = eo; v.e_es = es;
    tbl[tbl.size()-1] = v;
  endtask

  task automatic exp_out(input logic [63:0] el, input logic m, input logic [31:0] ad,
                         input logic w, input logic [31:0] st, input logic [31:0] en,
                         input logic [31:0] lat, input logic eo, input logic es);
    vec_t v;
    v = tbl[tbl.size()-1];
    v.chk = 1'b1; v.e_ov = 1'b1; v.e_elem = el; v.e_mem = m; v.e_addr = ad; v.e_we = w;
    v.e_start = st; v.e_end = en; v.e_lat = lat; v.e_eo = eo; v.e_es = es;
    tbl[tbl.size()-1] = v;
  endtask

  task automatic set_idle();
    in_valid = 1'b0; in_elem = '0; in_is_mem = 1'b0;
    data_mem_req = 1'b0; data_mem_addr = '0; data_mem_we = 1'b0;
    data_mem_grant = 1'b0; data_mem_rvalid = 1'b0;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic grant(input logic [31:0] c, input logic [31:0] ad, input logic w);
    data_mem_req = 1'b1; data_mem_grant = 1'b1; data_mem_addr = ad; data_mem_we = w;
    counter = c;
    cycle();
    set_idle();
  endtask

  task automatic rvalid(input logic [31:0] c);
    data_mem_rvalid = 1'b1; counter = c;
    cycle();
    set_idle();
  endtask

  task automatic push(input logic [63:0] el, input logic m);
    in_valid = 1'b1; in_elem = el; in_is_mem = m;
    cycle();
    set_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic early;

    // Vector table: each row is one cycle; checks apply after that cycle's edge.
    add(1, 64'h11, 0, 0, 0, 0, 0, 0, 1);                 exp_idle(0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 2);                      exp_out(64'h11, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 3);                      exp_idle(0, 0);
    add(1, 64'h22, 1, 0, 0, 0, 0, 0, 90);                exp_idle(0, 0);
    add(0, 0, 0, 1, 32'h8000_0010, 0, 1, 0, 100);        exp_idle(0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 101);
    add(0, 0, 0, 0, 0, 0, 0, 1, 105);                    exp_idle(0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 106);
    exp_out(64'h22, 1, 32'h8000_0010, 0, 100, 105, 5, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 107);                    exp_idle(0, 0);
    add(0, 0, 0, 1, 32'h0, 0, 1, 0, 10);
    add(0, 0, 0, 1, 32'h4, 1, 1, 0, 11);
    add(0, 0, 0, 1, 32'h8, 0, 1, 0, 12);
    add(0, 0, 0, 1, 32'hC, 1, 1, 0, 13);
    for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 0, 0, 0, 1, 32'(20 + i));
    add(1, 64'h30, 1, 0, 0, 0, 0, 0, 30);                exp_idle(0, 0);
    add(1, 64'h31, 1, 0, 0, 0, 0, 0, 31);                exp_out(64'h30, 1, 32'h0, 0, 10, 20, 10, 0, 0);
    add(1, 64'h32, 1, 0, 0, 0, 0, 0, 32);                exp_idle(0, 0);
    add(1, 64'h33, 1, 0, 0, 0, 0, 0, 33);                exp_out(64'h31, 1, 32'h4, 1, 11, 21, 10, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 34);                     exp_idle(0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 35);                     exp_out(64'h32, 1, 32'h8, 0, 12, 22, 10, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 36);                     exp_idle(0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 37);                     exp_out(64'h33, 1, 32'hC, 1, 13, 23, 10, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 38);                     exp_idle(0, 0);
    for (int i = 0; i < 4; i++) add(0, 0, 0, 1, 32'(32'h100 + 4 * i), 0, 1, 0, 32'(40 + i));
    exp_idle(0, 0);
    add(0, 0, 0, 1, 32'h110, 0, 1, 0, 44);               exp_idle(1, 0);
    for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 0, 0, 0, 1, 32'(50 + i));
    exp_idle(1, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1, 54);                     exp_idle(1, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 55);                     exp_idle(1, 1);
    add(1, 64'h44, 1, 0, 0, 0, 0, 0, 56);                exp_idle(1, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 57);
    exp_out(64'h44, 1, 32'h100, 0, 40, 50, 10, 1, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 58);                     exp_idle(1, 1);

    // Reset state
    set_idle();
    counter = '0; out_ready = 1'b1; rst = 1'b1;
    repeat (2) cycle();
    cmp("rst out_valid", out_valid, 0);
    cmp("rst in_ready", in_ready, 1);
    cmp("rst out_elem", out_elem, 0);
    cmp("rst out_latency", out_latency, 0);
    cmp("rst err_overflow", err_overflow, 0);
    cmp("rst err_spurious", err_spurious, 0);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      in_valid = tbl[i].iv; in_elem = tbl[i].elem; in_is_mem = tbl[i].im;
      data_mem_req = tbl[i].req; data_mem_addr = tbl[i].addr; data_mem_we = tbl[i].we;
      data_mem_grant = tbl[i].gnt; data_mem_rvalid = tbl[i].rv; counter = tbl[i].cnt;
      cycle();
      if (tbl[i].chk) begin
        cmp($sformatf("v%0d out_valid", i), out_valid, tbl[i].e_ov);
        cmp($sformatf("v%0d in_ready", i), in_ready, 1);
        cmp($sformatf("v%0d err_overflow", i), err_overflow, tbl[i].e_eo);
        cmp($sformatf("v%0d err_spurious", i), err_spurious, tbl[i].e_es);
        if (tbl[i].e_ov) begin
          cmp($sformatf("v%0d out_elem", i), out_elem, tbl[i].e_elem);
          cmp($sformatf("v%0d out_is_mem", i), out_is_mem, tbl[i].e_mem);
          cmp($sformatf("v%0d out_mem_addr", i), out_mem_addr, tbl[i].e_addr);
          cmp($sformatf("v%0d out_we", i), out_we, tbl[i].e_we);
          cmp($sformatf("v%0d out_start", i), out_start, tbl[i].e_start);
          cmp($sformatf("v%0d out_end", i), out_end, tbl[i].e_end);
          cmp($sformatf("v%0d out_latency", i), out_latency, tbl[i].e_lat);
          cmp($sformatf("v%0d out_timeout", i), out_timeout, 0);
        end
      end
    end
    set_idle();

    // Timeout after 8 WAIT_TXN cycles, then a late transaction pairs with the next element
    rst = 1'b1; cycle(); rst = 1'b0;
    push(64'h55, 1);
    early = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      cycle();
      if (out_valid) early = 1'b1;
    end
    cmp("timeout early out_valid", early, 0);
    cycle();
    cmp("timeout out_valid", out_valid, 1);
    cmp("timeout out_timeout", out_timeout, 1);
    cmp("timeout out_elem", out_elem, 64'h55);
    cmp("timeout out_mem_addr", out_mem_addr, 0);
    cmp("timeout out_start", out_start, 0);
    cmp("timeout out_latency", out_latency, 0);
    cycle();
    cmp("timeout drained", out_valid, 0);
    grant(200, 32'hA0, 1);
    counter = 203; cycle();
    rvalid(207);
    repeat (3) cycle();
    push(64'h66, 1);
    cycle();
    cmp("late txn out_valid", out_valid, 1);
    cmp("late txn out_elem", out_elem, 64'h66);
    cmp("late txn out_start", out_start, 200);
    cmp("late txn out_end", out_end, 207);
    cmp("late txn out_latency", out_latency, 7);
    cmp("late txn out_we", out_we, 1);
    cmp("late txn out_timeout", out_timeout, 0);
    cycle();

    // Counter wrap with the sink stalled
    grant(32'hFFFF_FFFE, 32'hC0, 0);
    counter = 32'hFFFF_FFFF; cycle();
    rvalid(32'h0000_0001);
    out_ready = 1'b0;
    push(64'h77, 1);
    cycle();
    cmp("wrap out_valid", out_valid, 1);
    cmp("wrap out_start", out_start, 32'hFFFF_FFFE);
    cmp("wrap out_end", out_end, 32'h1);
    cmp("wrap out_latency", out_latency, 3);
    repeat (3) cycle();
    cmp("stall out_valid held", out_valid, 1);
    cmp("stall out_elem held", out_elem, 64'h77);
    cmp("stall out_latency held", out_latency, 3);
    out_ready = 1'b1;
    cycle();
    cmp("stall released", out_valid, 0);

    // Spurious rvalid, then reset in the middle of WAIT_TXN
    rvalid(400);
    cmp("spurious err_spurious", err_spurious, 1);
    cmp("spurious err_overflow", err_overflow, 0);
    push(64'h88, 1);
    grant(300, 32'hE0, 0);
    repeat (2) cycle();
    cmp("wait out_valid", out_valid, 0);
    rst = 1'b1; cycle(); rst = 1'b0;
    cmp("midrst out_valid", out_valid, 0);
    cmp("midrst in_ready", in_ready, 1);
    cmp("midrst err_spurious", err_spurious, 0);
    cmp("midrst out_elem", out_elem, 0);
    rvalid(410);
    cmp("midrst pending flushed", err_spurious, 1);
    repeat (12) cycle();
    cmp("midrst elem flushed", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_mem_tracker.md
Name: ex_mem_tracker

Overview:
- Execute-stage trace tracker that pairs in-order instruction trace elements with data-memory transactions.
- Supports up to MAX_OUTSTANDING pipelined transactions. Each transaction starts on the req&grant cycle and ends on its rvalid.
- Records, per element: start time, end time, address, write flag and latency. Adds a timeout mode and protocol error flags.
- Sits between the ID-stage tracker (element source) and the trace output buffer (sink).

Parameters:
- DATA_ADDR_WIDTH, 32, data memory address width.
- ELEM_WIDTH, 64, width of the opaque trace element passed through.
- CNT_WIDTH, 32, width of the free-running cycle counter and of all timestamps.
- ELEM_DEPTH, 16, element FIFO depth (power of 2, ≥2).
- MAX_OUTSTANDING, 4, pending (granted, no rvalid yet) transaction FIFO depth (power of 2, ≥1).
- TXN_DEPTH, 8, completed-transaction FIFO depth (power of 2, ≥1).
- TIMEOUT, 1024, cycles a memory element waits for a completed transaction; 0 disables the timeout.

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst  in  1  reset, synchronous, active-high.
- counter  in  CNT_WIDTH  global cycle counter.
- in_valid  in  1  trace element valid.
- in_ready  out  1  element FIFO not full.
- in_elem  in  ELEM_WIDTH  trace element.
- in_is_mem  in  1  element is a load/store.
- data_mem_req  in  1  data request.
- data_mem_addr  in  DATA_ADDR_WIDTH  request address.
- data_mem_we  in  1  request is a write.
- data_mem_grant  in  1  request granted.
- data_mem_rvalid  in  1  response valid.
- out_valid  out  1  result valid.
- out_ready  in  1  sink accepts.
- out_elem  out  ELEM_WIDTH  passed-through element.
- out_is_mem  out  1  element was a memory op.
- out_mem_addr  out  DATA_ADDR_WIDTH  transaction address.
- out_we  out  1  transaction write flag.
- out_start  out  CNT_WIDTH  grant timestamp.
- out_end  out  CNT_WIDTH  rvalid timestamp.
- out_latency  out  CNT_WIDTH  out_end − out_start, modulo 2^CNT_WIDTH.
- out_timeout  out  1  memory element emitted without a transaction.
- err_overflow  out  1  sticky: grant while pending FIFO full, or rvalid while completed FIFO full.
- err_spurious  out  1  sticky: rvalid while pending FIFO empty.

Behaviour:
- Reset: all FIFOs empty, FSM in IDLE, timer 0. All outputs 0 except in_ready = 1. Reset mid-operation discards all in-flight state; error flags clear only on reset.
- Element FIFO: push {in_elem, in_is_mem} when in_valid && in_ready. in_ready = !full, registered-free.
- Pending FIFO: push {data_mem_addr, data_mem_we, counter} on data_mem_req && data_mem_grant.
  - If full: the push is dropped and err_overflow is set.
- rvalid: pops the pending head and pushes {addr, we, start, end = counter} into the completed FIFO.
  - Pending empty: set err_spurious, no push.
  - Completed FIFO full: the result is dropped and err_overflow is set.
  - An rvalid never matches a grant in the same cycle, because the push is visible next cycle.
  - Simultaneous grant and rvalid with a non-empty pending FIFO: pop and push both occur, and the count is unchanged.
- FSM:
  - IDLE: if the element FIFO is non-empty:
    - Head is non-mem: capture the element with memory fields 0, pop, go to EMIT.
    - Head is mem and the completed FIFO is non-empty: capture both, pop both, go to EMIT.
    - Otherwise: go to WAIT_TXN with timer = 0.
  - WAIT_TXN:
    - Completed FIFO non-empty: capture and pop both, go to EMIT.
    - Else if TIMEOUT ≠ 0 and timer == TIMEOUT−1: pop the element, capture with memory fields 0 and out_timeout = 1, go to EMIT.
    - Else: timer++.
  - EMIT: out_valid = 1 and outputs held stable; when out_ready is high, go to IDLE.
- Latency: an element whose transaction has already completed produces out_valid 2 cycles after its push cycle (1 cycle FIFO visibility, 1 cycle capture). Throughput is 1 result per 2 cycles.
- Timestamps are raw counter values. out_latency is computed with wrap, e.g. start = 0xFFFFFFFE and end = 0x00000001 gives latency 3.
- A completed transaction arriving before its element is retained in order and is never discarded by timeout.

Test Plan:
- Non-mem element, elem = 0x11, out_ready held high → out_valid 2 cycles after push; out_is_mem = 0; start = end = latency = 0; out_timeout = 0.
- Load with grant at counter = 100, addr 0x8000_0010, rvalid at 105; element pushed at 90 → out_start 100, out_end 105, out_latency 5, out_mem_addr 0x8000_0010, out_we = 0.
- Four back-to-back grants at counters 10–13 (addr 0x0, 0x4, 0x8, 0xC), rvalids at 20–23, four mem elements → four outputs in order, latency 10 each, no error flags.
- Fifth grant while 4 pending (MAX_OUTSTANDING = 4) → err_overflow = 1 and stays set. An rvalid with nothing pending → err_spurious = 1.
- TIMEOUT = 8, mem element with no transaction → out_valid with out_timeout = 1 after 8 WAIT_TXN cycles. A later completed transaction pairs with the next mem element.
- Counter wrap: grant at 0xFFFF_FFFE, rvalid at 0x0000_0001 → out_latency = 3. Assert rst mid-WAIT_TXN → next cycle out_valid = 0, in_ready = 1, all FIFOs empty.
